pixel_axis_sink: RTL and testbench

Receiving end of the pixel generator's result handshake: accepts one computed pixel per `pix_valid`/`pix_ready` transfer (coordinates plus 24-bit colour) and re-emits it as an AXI4-Stream video beat for the display/VDMA path. Start-of-frame (`tuser`) and end-of-line (`tlast`) are derived from the pixel coordinates. A FIFO decouples the variable-latency depth calculator from display backpressure. Sits between the pixel generator top level and the video output IP.

---
 rtl/pixel_axis_sink.sv | 132 +++++++++++++
 tb/tb_pixel_axis_sink.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_axis_sink.sv
// Pixel-generator result sink: FIFO-buffered conversion to AXI4-Stream video with SOF/EOL tagging.
// Define PIXEL_AXIS_SINK_ORDER_CHECK_EN to enable the sticky raster-order checker (seq_err).
module pixel_axis_sink #(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned COLOR_WIDTH = 24
) (
   input  logic                         sysclk,
   input  logic                         reset,
   input  logic [10:0]                  screen_width,
   input  logic [10:0]                  screen_height,
   input  logic                         pix_valid,
   output logic                         pix_ready,
   input  logic [10:0]                  pix_x,
   input  logic [10:0]                  pix_y,
   input  logic [COLOR_WIDTH-1:0]       pix_color,
   output logic [31:0]                  m_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic                         m_axis_tuser,
   output logic                         m_axis_tlast,
   output logic                         frame_done,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                         seq_err
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned EW = COLOR_WIDTH + 3;

   typedef logic [AW:0]   cnt_t;
   typedef logic [AW-1:0] ptr_t;

   localparam cnt_t FULL_CNT = cnt_t'(FIFO_DEPTH);

   logic [EW-1:0]          mem_q [FIFO_DEPTH];
   ptr_t                   wr_ptr_q, rd_ptr_q;
   cnt_t                   count_q, count_d;
   logic                   ready_q;
   logic [10:0]            width_m1, height_m1;
   logic                   sof_d, eol_d, eof_d;
   logic [EW-1:0]          entry_d, head;
   logic                   wr_en, load, rd_en;
   logic                   tvalid_q, tuser_q, tlast_q, eof_q, frame_done_q;
   logic [COLOR_WIDTH-1:0] color_q;

   assign width_m1  = screen_width - 11'd1;
   assign height_m1 = screen_height - 11'd1;

   always_comb begin
      sof_d   = (pix_x == '0) && (pix_y == '0);
      eol_d   = (pix_x == width_m1);
      eof_d   = eol_d && (pix_y == height_m1);
      entry_d = {pix_color, sof_d, eol_d, eof_d};
   end

   // Output register refills whenever it is empty or its beat is being taken.
   assign wr_en = pix_valid && ready_q;
   assign load  = !tvalid_q || m_axis_tready;
   assign rd_en = load && (count_q != '0);
   assign head  = mem_q[rd_ptr_q];

   always_comb count_d = count_q + cnt_t'(wr_en) - cnt_t'(rd_en);

   always_ff @(posedge sysclk) begin
      if (wr_en) mem_q[wr_ptr_q] <= entry_d;
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + ptr_t'(1);
         count_q <= count_d;
         ready_q <= (count_d != FULL_CNT);
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         tvalid_q     <= 1'b0;
         color_q      <= '0;
         tuser_q      <= 1'b0;
         tlast_q      <= 1'b0;
         eof_q        <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         if (load) begin
            tvalid_q <= rd_en;
            if (rd_en) {color_q, tuser_q, tlast_q, eof_q} <= head;
         end
         frame_done_q <= tvalid_q && m_axis_tready && eof_q;
      end
   end

   assign pix_ready     = ready_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = 32'(color_q);
   assign m_axis_tuser  = tuser_q;
   assign m_axis_tlast  = tlast_q;
   assign frame_done    = frame_done_q;
   assign fifo_level    = count_q;

`ifdef PIXEL_AXIS_SINK_ORDER_CHECK_EN
   logic [10:0] ex_q, ey_q;
   logic        seq_err_q;

   // Expected position always resyncs to the received coordinate plus one.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         ex_q      <= '0;
         ey_q      <= '0;
         seq_err_q <= 1'b0;
      end else if (wr_en) begin
         if ((pix_x != ex_q) || (pix_y != ey_q)) seq_err_q <= 1'b1;
         if (pix_x >= width_m1) begin
            ex_q <= '0;
            ey_q <= (pix_y >= height_m1) ? 11'd0 : pix_y + 11'd1;
         end else begin
            ex_q <= pix_x + 11'd1;
            ey_q <= pix_y;
         end
      end
   end

   assign seq_err = seq_err_q;
`else
   assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_axis_sink.sv
// Self-checking bench for pixel_axis_sink against a raster-rule reference model.
`timescale 1ns/1ps
module tb_pixel_axis_sink;
   localparam int unsigned DEPTH = 16;
`ifdef PIXEL_AXIS_SINK_ORDER_CHECK_EN
   localparam logic ORDER_EN = 1'b1;
`else
   localparam logic ORDER_EN = 1'b0;
`endif

   logic        sysclk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] screen_width = 11'd4;
   logic [10:0] screen_height = 11'd2;
   logic        pix_valid = 1'b0;
   logic        pix_ready;
   logic [10:0] pix_x = '0;
   logic [10:0] pix_y = '0;
   logic [23:0] pix_color = '0;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        m_axis_tuser;
   logic        m_axis_tlast;
   logic        frame_done;
   logic [4:0]  fifo_level;
   logic        seq_err;

   int passed = 0;
   int total  = 0;

   typedef struct { int x; int y; logic [23:0] c; } pix_t;
   pix_t        pixq[$];
   logic [33:0] got_q[$];
   int          got_cyc[$];
   int          fd_cyc[$];
   logic [33:0] exp_q[$];
   int          exp_fd[$];
   int          stab_err;

   always #5 sysclk = ~sysclk;

   pixel_axis_sink #(.FIFO_DEPTH(DEPTH), .COLOR_WIDTH(24)) dut (
      .sysclk(sysclk), .reset(reset),
      .screen_width(screen_width), .screen_height(screen_height),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
      .frame_done(frame_done), .fifo_level(fifo_level), .seq_err(seq_err)
   );

   // Reference: one beat per pixel in order; tuser at (0,0), tlast at x==w-1, frame_done one cycle after eof beat.
   function automatic void build_exp(input int w, input int h);
      logic sof, eol, eof;
      exp_q.delete();
      exp_fd.delete();
      foreach (pixq[i]) begin
         sof = (pixq[i].x == 0) && (pixq[i].y == 0);
         eol = (pixq[i].x == w - 1);
         eof = eol && (pixq[i].y == h - 1);
         exp_q.push_back({8'h00, pixq[i].c, sof, eol});
         if (eof && i < got_cyc.size()) exp_fd.push_back(got_cyc[i] + 1);
      end
   endfunction

   function automatic void fill_frame(input int w, input int h, input bit idx_color);
      pixq.delete();
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            pixq.push_back('{x: x, y: y, c: idx_color ? 24'(y * w + x) : 24'($urandom)});
   endfunction

   task automatic do_reset(input int w, input int h);
      @(negedge sysclk);
      reset = 1'b1;
      pix_valid = 1'b0;
      m_axis_tready = 1'b0;
      screen_width = 11'(w);
      screen_height = 11'(h);
      repeat (2) @(negedge sysclk);
      reset = 1'b0;
      @(negedge sysclk);
   endtask

   // Drives pixq with random valid/ready and records every output handshake (no checking here).
   task automatic collect(input int rdy_pct, input int vld_pct, input int max_cyc);
      int idx = 0;
      int cyc = 0;
      int tail = 0;
      bit stall = 1'b0;
      logic [33:0] snap = '0;
      got_q.delete(); got_cyc.delete(); fd_cyc.delete();
      stab_err = 0;
      while (cyc < max_cyc && tail < 4) begin
         @(negedge sysclk);
         cyc++;
         if (stall && (!m_axis_tvalid || {m_axis_tdata, m_axis_tuser, m_axis_tlast} !== snap)) stab_err++;
         if (frame_done) fd_cyc.push_back(cyc);
         if (got_q.size() >= pixq.size()) tail++;
         pix_valid = (idx < pixq.size()) && (int'($urandom_range(99)) < vld_pct);
         if (idx < pixq.size()) begin
            pix_x = 11'(pixq[idx].x);
            pix_y = 11'(pixq[idx].y);
            pix_color = pixq[idx].c;
         end
         m_axis_tready = (int'($urandom_range(99)) < rdy_pct);
         if (pix_valid && pix_ready) idx++;
         if (m_axis_tvalid && m_axis_tready) begin
            got_q.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast});
            got_cyc.push_back(cyc);
         end
         stall = m_axis_tvalid && !m_axis_tready;
         snap = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
      end
      pix_valid = 1'b0;
      m_axis_tready = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      total++;
      if ({pix_ready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, seq_err} !== 6'b0)
         $display("FAIL reset_flags: got %b want 000000", {pix_ready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, seq_err});
      else passed++;
      total++;
      if (m_axis_tdata !== 32'd0 || fifo_level !== 5'd0)
         $display("FAIL reset_data: got tdata %h level %0d want 0 0", m_axis_tdata, fifo_level);
      else passed++;
      @(negedge sysclk);
      reset = 1'b0;
      #1;
      total++;
      if (pix_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", pix_ready); else passed++;
      @(negedge sysclk);
      total++;
      if (pix_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", pix_ready); else passed++;
   endtask

   task automatic test_latency;
      do_reset(4, 2);
      pix_valid = 1'b1; pix_x = '0; pix_y = '0; pix_color = 24'h5AA53C;
      m_axis_tready = 1'b1;
      @(negedge sysclk);
      pix_valid = 1'b0;
      total++;
      if (m_axis_tvalid !== 1'b0 || fifo_level !== 5'd1)
         $display("FAIL latency_k: got tvalid %b level %0d want 0 1", m_axis_tvalid, fifo_level);
      else passed++;
      @(negedge sysclk);
      total++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, fifo_level} !== {1'b1, 32'h005AA53C, 1'b1, 1'b0, 5'd0})
         $display("FAIL latency_k1: got v%b d%h u%b l%b lvl%0d want v1 d005aa53c u1 l0 lvl0",
                  m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, fifo_level);
      else passed++;
      @(negedge sysclk);
      total++;
      if (m_axis_tvalid !== 1'b0) $display("FAIL latency_drain: got tvalid %b want 0", m_axis_tvalid); else passed++;
      m_axis_tready = 1'b0;
   endtask

   task automatic test_frame_4x2;
      logic [33:0] a;
      do_reset(4, 2);
      fill_frame(4, 2, 1'b1);
      collect(100, 100, 200);
      build_exp(4, 2);
      total++;
      if (got_q.size() != 8) $display("FAIL frame_count: got %0d want 8", got_q.size()); else passed++;
      foreach (exp_q[i]) begin
         a = (i < got_q.size()) ? got_q[i] : 34'bx;
         total++;
         if (a !== exp_q[i]) $display("FAIL frame_beat[%0d]: got %h want %h", i, a, exp_q[i]); else passed++;
      end
      total++;
      if (fd_cyc.size() != 1 || exp_fd.size() != 1 || fd_cyc[0] != exp_fd[0])
         $display("FAIL frame_done: got %0d pulses want 1 at cycle after last beat", fd_cyc.size());
      else passed++;
      total++;
      if (seq_err !== 1'b0) $display("FAIL frame_seq_err: got %b want 0", seq_err); else passed++;
   endtask

   task automatic test_backpressure;
      logic [33:0] a;
      int idx = 0;
      pixq.delete();
      for (int i = 0; i < 32; i++) pixq.push_back('{x: i, y: 0, c: 24'($urandom)});
      do_reset(64, 24);
      for (int c = 0; c < 30; c++) begin
         pix_valid = 1'b1;
         pix_x = 11'(pixq[idx].x);
         pix_y = 11'(pixq[idx].y);
         pix_color = pixq[idx].c;
         if (pix_ready) idx++;
         @(negedge sysclk);
      end
      pix_valid = 1'b0;
      total++;
      if (idx != DEPTH + 1) $display("FAIL bp_accepted: got %0d want %0d", idx, DEPTH + 1); else passed++;
      total++;
      if (pix_ready !== 1'b0 || fifo_level !== 5'd16)
         $display("FAIL bp_full: got ready %b level %0d want 0 16", pix_ready, fifo_level);
      else passed++;
      got_q.delete();
      m_axis_tready = 1'b1;
      if (m_axis_tvalid) got_q.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast});
      @(negedge sysclk);
      total++;
      if (pix_ready !== 1'b1 || fifo_level !== 5'd15)
         $display("FAIL bp_first_read: got ready %b level %0d want 1 15", pix_ready, fifo_level);
      else passed++;
      for (int c = 0; c < 40 && got_q.size() < 18; c++) begin
         if (m_axis_tvalid) got_q.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast});
         @(negedge sysclk);
      end
      m_axis_tready = 1'b0;
      pixq = pixq[0:DEPTH];
      build_exp(64, 24);
      total++;
      if (got_q.size() != DEPTH + 1) $display("FAIL bp_count: got %0d want %0d", got_q.size(), DEPTH + 1); else passed++;
      foreach (exp_q[i]) begin
         a = (i < got_q.size()) ? got_q[i] : 34'bx;
         total++;
         if (a !== exp_q[i]) $display("FAIL bp_beat[%0d]: got %h want %h", i, a, exp_q[i]); else passed++;
      end
   endtask

   task automatic test_random_frame;
      int nlast = 0;
      int nuser = 0;
      int bad = 0;
      do_reset(64, 24);
      fill_frame(64, 24, 1'b0);
      collect(65, 80, 20000);
      build_exp(64, 24);
      total++;
      if (got_q.size() != 1536) $display("FAIL rand_count: got %0d want 1536", got_q.size()); else passed++;
      foreach (got_q[i]) begin
         nlast += int'(got_q[i][0]);
         nuser += int'(got_q[i][1]);
         if (i < exp_q.size() && got_q[i] !== exp_q[i]) begin
            if (bad < 5) $display("FAIL rand_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            bad++;
         end
      end
      total++;
      if (bad != 0) $display("FAIL rand_beats: got %0d wrong beats want 0", bad); else passed++;
      total++;
      if (nlast != 24) $display("FAIL rand_tlast: got %0d want 24", nlast); else passed++;
      total++;
      if (nuser != 1) $display("FAIL rand_tuser: got %0d want 1", nuser); else passed++;
      total++;
      if (stab_err != 0) $display("FAIL rand_stable: got %0d unstable stalls want 0", stab_err); else passed++;
      total++;
      if (fd_cyc.size() != 1 || exp_fd.size() != 1 || fd_cyc[0] != exp_fd[0])
         $display("FAIL rand_frame_done: got %0d pulses want 1 at cycle after last beat", fd_cyc.size());
      else passed++;
   endtask

   task automatic test_reset_flush;
      logic [33:0] a;
      int idx = 0;
      do_reset(4, 2);
      fill_frame(4, 2, 1'b1);
      for (int c = 0; c < 20 && idx < 5; c++) begin
         pix_valid = 1'b1;
         pix_x = 11'(pixq[idx].x);
         pix_y = 11'(pixq[idx].y);
         pix_color = pixq[idx].c;
         if (pix_ready) idx++;
         @(negedge sysclk);
      end
      pix_valid = 1'b0;
      total++;
      if (m_axis_tvalid !== 1'b1 || fifo_level !== 5'd4)
         $display("FAIL flush_pending: got tvalid %b level %0d want 1 4", m_axis_tvalid, fifo_level);
      else passed++;
      #2 reset = 1'b1;
      #1;
      total++;
      if ({m_axis_tvalid, pix_ready, fifo_level} !== 7'b0)
         $display("FAIL flush_async: got tvalid %b ready %b level %0d want 0 0 0", m_axis_tvalid, pix_ready, fifo_level);
      else passed++;
      do_reset(4, 2);
      fill_frame(4, 2, 1'b0);
      collect(70, 90, 300);
      build_exp(4, 2);
      total++;
      if (got_q.size() != 8) $display("FAIL flush_count: got %0d want 8", got_q.size()); else passed++;
      foreach (exp_q[i]) begin
         a = (i < got_q.size()) ? got_q[i] : 34'bx;
         total++;
         if (a !== exp_q[i]) $display("FAIL flush_beat[%0d]: got %h want %h", i, a, exp_q[i]); else passed++;
      end
   endtask

   task automatic test_seq_check;
      int xs[3] = '{0, 2, 3};
      logic want[3];
      want[0] = 1'b0; want[1] = ORDER_EN; want[2] = ORDER_EN;
      do_reset(4, 2);
      m_axis_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pix_valid = 1'b1; pix_x = 11'(xs[i]); pix_y = '0; pix_color = 24'(i);
         @(negedge sysclk);
         pix_valid = 1'b0;
         @(negedge sysclk);
         total++;
         if (seq_err !== want[i]) $display("FAIL seq_err_after_x%0d: got %b want %b", xs[i], seq_err, want[i]); else passed++;
      end
      m_axis_tready = 1'b0;
   endtask

   task automatic test_width1_offscreen;
      logic [33:0] a;
      do_reset(1, 3);
      fill_frame(1, 3, 1'b0);
      collect(60, 100, 200);
      build_exp(1, 3);
      total++;
      if (got_q.size() != 3) $display("FAIL w1_count: got %0d want 3", got_q.size()); else passed++;
      foreach (exp_q[i]) begin
         a = (i < got_q.size()) ? got_q[i] : 34'bx;
         total++;
         if (a !== exp_q[i]) $display("FAIL w1_beat[%0d]: got %h want %h", i, a, exp_q[i]); else passed++;
      end
      total++;
      if (fd_cyc.size() != 1 || exp_fd.size() != 1 || fd_cyc[0] != exp_fd[0])
         $display("FAIL w1_frame_done: got %0d pulses want 1 at cycle after third beat", fd_cyc.size());
      else passed++;
      do_reset(4, 2);
      pixq.delete();
      pixq.push_back('{x: 5, y: 1, c: 24'($urandom)});
      pixq.push_back('{x: 4, y: 0, c: 24'($urandom)});
      pixq.push_back('{x: 3, y: 1, c: 24'($urandom)});
      collect(100, 100, 100);
      build_exp(4, 2);
      foreach (exp_q[i]) begin
         a = (i < got_q.size()) ? got_q[i] : 34'bx;
         total++;
         if (a !== exp_q[i]) $display("FAIL offscreen_beat[%0d]: got %h want %h", i, a, exp_q[i]); else passed++;
      end
      total++;
      if (fd_cyc.size() != 1 || exp_fd.size() != 1 || fd_cyc[0] != exp_fd[0])
         $display("FAIL offscreen_frame_done: got %0d pulses want 1", fd_cyc.size());
      else passed++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_latency();
      test_frame_4x2();
      test_backpressure();
      test_random_frame();
      test_reset_flush();
      test_seq_check();
      test_width1_offscreen();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
